// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//
// Receives a serial configuration frame (LSB-first bytes, qualified by
// sin_valid) and turns each data byte into a one-cycle register write for the
// connection-block configuration registers.
//
// Frame: 0xA5 header, count N (1..NUM_BLOCKS), N data bytes, then a checksum
// byte equal to the XOR of the N data bytes.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous active-low reset
//   start      one-cycle pulse, begins (or restarts) a frame
//   sin        serial data bit
//   sin_valid  sin qualifier; a bit is consumed only when high
//   cfg_data   byte to load into the addressed register (held between writes)
//   cfg_addr   register index (held between writes)
//   cfg_we     one-cycle write strobe for cfg_data/cfg_addr
//   busy       high while a frame is in progress
//   done       one-cycle pulse on a frame with a good checksum
//   error      sticky frame error, cleared by start or reset
// -----------------------------------------------------------------------------
module config_loader #(
    parameter int NUM_BLOCKS = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [7:0]        cfg_data,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic              cfg_we,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] MAX_N    = 8'(NUM_BLOCKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CNT,
        S_DATA,
        S_CHK
    } state_t;

    state_t            state_q,    state_d;
    logic [2:0]        bit_cnt_q,  bit_cnt_d;
    logic [6:0]        shreg_q,    shreg_d;     // first seven bits of the byte
    logic [7:0]        idx_q,      idx_d;       // data byte index k
    logic [7:0]        count_q,    count_d;     // latched N
    logic [7:0]        xor_q,      xor_d;       // running XOR of data bytes
    logic [7:0]        cfg_data_q, cfg_data_d;
    logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
    logic              cfg_we_q,   cfg_we_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              error_q,    error_d;

    // LSB-first: the eighth valid bit is the MSB of the completed byte.
    logic [7:0] new_byte;
    logic       byte_done;

    assign new_byte  = {sin, shreg_q};
    assign byte_done = sin_valid && (bit_cnt_q == 3'd7);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        count_d    = count_q;
        xor_d      = xor_q;
        cfg_data_d = cfg_data_q;
        cfg_addr_d = cfg_addr_q;
        cfg_we_d   = 1'b0;
        done_d     = 1'b0;
        error_d    = error_q;

        if (start) begin
            // Start wins over any bit arriving in the same cycle and aborts
            // a frame in progress.
            state_d   = S_HDR;
            bit_cnt_d = 3'd0;
            shreg_d   = 7'd0;
            idx_d     = 8'd0;
            count_d   = 8'd0;
            xor_d     = 8'd0;
            error_d   = 1'b0;
        end else if (state_q != S_IDLE && sin_valid) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shreg_d   = {sin, shreg_q[6:1]};

            if (byte_done) begin
                unique case (state_q)
                    S_HDR: begin
                        if (new_byte == HDR_BYTE) begin
                            state_d = S_CNT;
                        end else begin
                            state_d = S_IDLE;
                            error_d = 1'b1;
                        end
                    end
                    S_CNT: begin
                        if (new_byte != 8'd0 && new_byte <= MAX_N) begin
                            count_d = new_byte;
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                            error_d = 1'b1;
                        end
                    end
                    S_DATA: begin
                        cfg_we_d   = 1'b1;
                        cfg_data_d = new_byte;
                        cfg_addr_d = idx_q[ADDR_W-1:0];
                        xor_d      = xor_q ^ new_byte;
                        idx_d      = idx_q + 8'd1;
                        if (idx_q == count_q - 8'd1) begin
                            state_d = S_CHK;
                        end
                    end
                    S_CHK: begin
                        state_d = S_IDLE;
                        if (new_byte == xor_q) begin
                            done_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // busy drops in the same cycle done/error is raised.
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 7'd0;
            idx_q      <= 8'd0;
            count_q    <= 8'd0;
            xor_q      <= 8'd0;
            cfg_data_q <= 8'd0;
            cfg_addr_q <= '0;
            cfg_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            xor_q      <= xor_d;
            cfg_data_q <= cfg_data_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_we_q   <= cfg_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign cfg_data = cfg_data_q;
    assign cfg_addr = cfg_addr_q;
    assign cfg_we   = cfg_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
